uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_byte_rx.sv | 145 ++++++++++++++
 tb/tb_uart_byte_rx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver with 16x oversampling and majority-vote sampling
module uart_byte_rx (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rs232_Rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       frame_err,
    output logic       uart_state
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      r_state, w_next;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic [1:0]  r_flush;
    logic        r_armed;
    logic [8:0]  r_div_cnt, r_div_max, w_div_sel;
    logic [3:0]  r_tick_cnt, r_bit_cnt;
    logic [7:0]  r_shift;
    logic [1:0]  r_samp;
    logic        r_bit;
    logic        w_fall, w_tick, w_maj;
    logic        w_start, w_done, w_ferr, w_shift_en;

    always_comb begin
        case (baud_set)
            3'd1:    w_div_sel = 9'd161;
            3'd2:    w_div_sel = 9'd80;
            3'd3:    w_div_sel = 9'd53;
            3'd4:    w_div_sel = 9'd26;
            default: w_div_sel = 9'd324;
        endcase
    end

    // A line already low when reset releases must not look like a start edge:
    // edges only count once the flushed synchroniser has shown the line high.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_flush   <= 2'd0;
            r_armed   <= 1'b0;
        end else begin
            r_rx_s1   <= Rs232_Rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (r_flush != 2'd2)
                r_flush <= r_flush + 2'd1;
            else if (r_rx_s2)
                r_armed <= 1'b1;
        end
    end

    assign w_fall     = r_armed & r_rx_prev & ~r_rx_s2;
    assign w_tick     = (r_state != IDLE) && (r_div_cnt == r_div_max);
    assign w_maj      = (r_samp[0] & r_samp[1]) | ((r_samp[0] | r_samp[1]) & r_rx_s2);
    assign uart_state = (r_state != IDLE);

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_done     = 1'b0;
        w_ferr     = 1'b0;
        w_shift_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_next  = START;
                    w_start = 1'b1;
                end
            end
            START: begin
                if (w_tick && r_tick_cnt == 4'd15)
                    w_next = r_bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_tick && r_tick_cnt == 4'd15) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 4'd7)
                        w_next = STOP;
                end
            end
            STOP: begin
                // Decide mid-bit so a back-to-back start edge is not missed.
                if (w_tick && r_tick_cnt == 4'd9) begin
                    w_next = IDLE;
                    if (w_maj)
                        w_done = 1'b1;
                    else
                        w_ferr = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_div_cnt  <= 9'd0;
            r_div_max  <= 9'd324;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_samp     <= 2'b00;
            r_bit      <= 1'b0;
            data_byte  <= 8'h00;
            Rx_Done    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_state   <= w_next;
            Rx_Done   <= w_done;
            frame_err <= w_ferr;
            if (w_done)
                data_byte <= r_shift;
            if (w_start) begin
                r_div_cnt  <= 9'd0;
                r_tick_cnt <= 4'd0;
                r_bit_cnt  <= 4'd0;
                r_div_max  <= w_div_sel;
            end else if (r_state != IDLE) begin
                if (w_tick) begin
                    r_div_cnt  <= 9'd0;
                    r_tick_cnt <= r_tick_cnt + 4'd1;
                    if (r_tick_cnt == 4'd7)
                        r_samp[0] <= r_rx_s2;
                    if (r_tick_cnt == 4'd8)
                        r_samp[1] <= r_rx_s2;
                    if (r_tick_cnt == 4'd9)
                        r_bit <= w_maj;
                end else begin
                    r_div_cnt <= r_div_cnt + 9'd1;
                end
            end
            if (w_shift_en) begin
                r_shift   <= {r_bit, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - directed/randomized bench for uart_byte_rx with a frame-level reference model
module tb_uart_byte_rx;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rs232_Rx = 1'b1;
    logic [2:0] baud_set = 3'd4;
    logic [7:0] data_byte;
    logic       Rx_Done, frame_err, uart_state;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] done_q[$];
    int         done_cyc_q[$];
    int         ferr_cyc_q[$];
    bit         prev_pulse = 1'b0;

    uart_byte_rx dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Rs232_Rx   (Rs232_Rx),
        .baud_set   (baud_set),
        .data_byte  (data_byte),
        .Rx_Done    (Rx_Done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    always #10 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Pulse monitor: records every Rx_Done / frame_err and checks exclusivity and single-cycle width.
    always @(negedge Clk) begin
        if (Rx_Done || frame_err) begin
            n_tests++;
            assert (!(Rx_Done && frame_err) && !prev_pulse)
            else begin
                n_fail++;
                $error("FAIL pulse_shape observed done=%0b ferr=%0b prev=%0b expected single exclusive pulse",
                       Rx_Done, frame_err, prev_pulse);
            end
            if (Rx_Done) begin
                done_q.push_back(data_byte);
                done_cyc_q.push_back(cyc);
            end
            if (frame_err)
                ferr_cyc_q.push_back(cyc);
        end
        prev_pulse = (Rx_Done === 1'b1) || (frame_err === 1'b1);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    function automatic int div_of(input logic [2:0] b);
        case (b)
            3'd1:    return 162;
            3'd2:    return 81;
            3'd3:    return 54;
            3'd4:    return 27;
            default: return 325;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        n_tests++;
        assert (obs >= exp - tol && obs <= exp + tol)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic clr();
        done_q.delete();
        done_cyc_q.delete();
        ferr_cyc_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Drives one 8N1 frame; optional one-cycle flip near sample tick 8 of bit glitch_bit
    // and optional random baud_set change after the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic [2:0] bs,
                              input int glitch_bit, input logic chg, output int fall);
        int   div;
        logic v;
        div      = div_of(bs);
        baud_set = bs;
        fall     = cyc;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : (i == 9) ? stop_v : b[i-1];
            for (int k = 0; k < 16 * div; k++) begin
                Rs232_Rx = (i == glitch_bit && k == 9 * div + 1) ? ~v : v;
                if (chg && i == 1 && k == 0)
                    baud_set = 3'($urandom_range(0, 7));
                @(negedge Clk);
            end
        end
        Rs232_Rx = 1'b1;
    endtask

    task automatic check_good(input string tag, input int idx, input int n,
                              input logic [7:0] b, input int fall, input int div);
        check({tag, "_ndone"}, done_q.size(), n);
        check({tag, "_nferr"}, ferr_cyc_q.size(), 0);
        check({tag, "_data"}, (done_q.size() > idx) ? {24'h0, done_q[idx]} : 32'hxxxxxxxx, {24'h0, b});
        check_near({tag, "_lat"}, (done_cyc_q.size() > idx) ? done_cyc_q[idx] - fall : -1,
                   154 * div + 3, 1);
    endtask

    task automatic start_glitch(input string tag, input logic [2:0] bs, input int len);
        int div, fall;
        bit busy;
        div      = div_of(bs);
        baud_set = bs;
        clr();
        fall     = cyc;
        Rs232_Rx = 1'b0;
        repeat (len) @(negedge Clk);
        busy     = uart_state;
        Rs232_Rx = 1'b1;
        for (int k = 0; k < 20 * div + 50; k++) begin
            @(negedge Clk);
            if (!uart_state) break;
        end
        check({tag, "_busy"}, busy, 1);
        check_near({tag, "_abort_time"}, cyc - fall, 16 * div + 3, 1);
        check({tag, "_pulses"}, done_q.size() + ferr_cyc_q.size(), 0);
        check({tag, "_hold"}, data_byte, exp_data);
    endtask

    initial begin
        int         f0, f1;
        logic [7:0] rb0, rb1;
        logic [7:0] b96;
        logic       v;

        // Reset values, with the line held low through reset release.
        Rs232_Rx = 1'b0;
        idle(3);
        check("rst_data", data_byte, 8'h00);
        check("rst_done", Rx_Done, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_state", uart_state, 1'b0);
        Rst = 1'b0;
        clr();
        idle(200);
        check("low_after_rst_state", uart_state, 1'b0);
        Rs232_Rx = 1'b1;
        idle(30);
        check("low_after_rst_state2", uart_state, 1'b0);
        check("low_after_rst_pulses", done_q.size() + ferr_cyc_q.size(), 0);

        // Back-to-back 0x55, 0xA3 at 115200.
        clr();
        send_frame(8'h55, 1'b1, 3'd4, -1, 1'b0, f0);
        send_frame(8'hA3, 1'b1, 3'd4, -1, 1'b0, f1);
        idle(20);
        check_good("b2b0", 0, 2, 8'h55, f0, 27);
        check_good("b2b1", 1, 2, 8'hA3, f1, 27);
        exp_data = 8'hA3;
        check("b2b_hold", data_byte, exp_data);

        // Random bytes with a mid-frame baud_set change that must not take effect.
        rb0 = 8'($urandom_range(0, 255));
        rb1 = 8'($urandom_range(0, 255));
        clr();
        send_frame(rb0, 1'b1, 3'd4, -1, 1'b1, f0);
        idle(20);
        check_good("rnd0", 0, 1, rb0, f0, 27);
        exp_data = rb0;
        clr();
        send_frame(rb1, 1'b1, 3'd3, -1, 1'b1, f0);
        idle(20);
        check_good("rnd1_b3", 0, 1, rb1, f0, 54);
        exp_data = rb1;
        check("rnd1_hold", data_byte, exp_data);

        // All-zeros and all-ones payloads.
        clr();
        send_frame(8'h00, 1'b1, 3'd4, -1, 1'b0, f0);
        send_frame(8'hFF, 1'b1, 3'd4, -1, 1'b0, f1);
        idle(20);
        check_good("zero", 0, 2, 8'h00, f0, 27);
        check_good("ones", 1, 2, 8'hFF, f1, 27);
        exp_data = 8'hFF;

        // Stop bit low: frame error, data unchanged.
        clr();
        send_frame(8'h3C, 1'b0, 3'd4, -1, 1'b0, f0);
        idle(20);
        check("stoplow_ndone", done_q.size(), 0);
        check("stoplow_nferr", ferr_cyc_q.size(), 1);
        check_near("stoplow_lat", (ferr_cyc_q.size() > 0) ? ferr_cyc_q[0] - f0 : -1, 154 * 27 + 3, 1);
        check("stoplow_hold", data_byte, exp_data);

        // Start-bit glitches at several rates; abort time reveals the divisor in use.
        start_glitch("glitch200_b4", 3'd4, 200);
        start_glitch("glitch_b0", 3'd0, 1000);
        start_glitch("glitch_b6", 3'd6, 1000);
        start_glitch("glitch_b1", 3'd1, 500);
        start_glitch("glitch_b2", 3'd2, 250);

        // One-cycle glitch on a data bit of 0x5A is outvoted.
        clr();
        send_frame(8'h5A, 1'b1, 3'd4, $urandom_range(1, 8), 1'b0, f0);
        idle(20);
        check_good("vote5A", 0, 1, 8'h5A, f0, 27);
        exp_data = 8'h5A;

        // Line held low for a whole frame, then left low.
        clr();
        baud_set = 3'd4;
        f0       = cyc;
        Rs232_Rx = 1'b0;
        idle(160 * 27);
        check("brk_nferr", ferr_cyc_q.size(), 1);
        check("brk_ndone", done_q.size(), 0);
        check_near("brk_lat", (ferr_cyc_q.size() > 0) ? ferr_cyc_q[0] - f0 : -1, 154 * 27 + 3, 1);
        check("brk_hold", data_byte, exp_data);
        idle(400);
        check("brk_no_restart", uart_state, 1'b0);
        Rs232_Rx = 1'b1;
        idle(50);

        // Reset pulsed during data bit 4 of 0x96.
        clr();
        b96      = 8'h96;
        baud_set = 3'd4;
        for (int i = 0; i < 5; i++) begin
            v = (i == 0) ? 1'b0 : b96[i-1];
            Rs232_Rx = v;
            idle((i == 4) ? 8 * 27 : 16 * 27);
        end
        Rst      = 1'b1;
        Rs232_Rx = 1'b1;
        @(negedge Clk);
        Rst      = 1'b0;
        exp_data = 8'h00;
        check("midrst_data", data_byte, exp_data);
        check("midrst_state", uart_state, 1'b0);
        check("midrst_done", Rx_Done, 1'b0);
        check("midrst_ferr", frame_err, 1'b0);
        idle(4500);
        check("midrst_pulses", done_q.size() + ferr_cyc_q.size(), 0);
        clr();
        send_frame(8'h96, 1'b1, 3'd4, -1, 1'b0, f0);
        idle(20);
        check_good("after_rst96", 0, 1, 8'h96, f0, 27);
        exp_data = 8'h96;
        check("final_hold", data_byte, exp_data);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
